// File: rtl/write_back_stage_pkg.sv
// Shared write-back types: result source select and load kind.
package write_back_stage_pkg;

  typedef enum logic [1:0] {
    WB_SEL_MEM = 2'd0,
    WB_SEL_ALU = 2'd1,
    WB_SEL_PC  = 2'd2,
    WB_SEL_CSR = 2'd3
  } write_back_select_t;

  // Encodings 5..7 are unused and decode as LW.
  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LH  = 3'd1,
    LT_LW  = 3'd2,
    LT_LBU = 3'd3,
    LT_LHU = 3'd4
  } load_type_t;

endpackage

// File: rtl/write_back_stage_if.sv
// Write-back stage bus: upstream instruction, load return, RF write and bypass.
interface write_back_stage_if
  import write_back_stage_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic               in_valid;
  logic               in_ready;
  write_back_select_t wb_sel;
  load_type_t         load_type;
  logic [1:0]         byte_off;
  logic [4:0]         rd_addr;
  logic               rd_we;
  logic [XLEN-1:0]    alu_in;
  logic [XLEN-1:0]    pc_in;
  logic [XLEN-1:0]    csr_in;
  logic               mem_rvalid;
  logic [XLEN-1:0]    mem_rdata;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [XLEN-1:0]    rf_wdata;
  logic               fwd_valid;
  logic [4:0]         fwd_addr;
  logic [XLEN-1:0]    fwd_data;
  logic               busy;

  modport master (
    output in_valid, wb_sel, load_type, byte_off, rd_addr, rd_we,
    output alu_in, pc_in, csr_in, mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data, busy
  );

  modport slave (
    input  in_valid, wb_sel, load_type, byte_off, rd_addr, rd_we,
    input  alu_in, pc_in, csr_in, mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data, busy
  );

endinterface

// File: rtl/write_back_stage_load_align.sv
// Load alignment and sign/zero extension of the raw memory word.
module load_align
  import write_back_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  load_type_t      load_type,
  input  logic [1:0]      byte_off,
  output logic [XLEN-1:0] data
);

  logic [31:0] word_lo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign word_lo  = word[31:0];
  assign half_sel = byte_off[1] ? word_lo[31:16] : word_lo[15:0];

  // Upper bits of a 64-bit word never contribute to a load result.
  if (XLEN > 32) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^word[XLEN-1:32];
  end

  // Byte lane picked by the low address bits
  always_comb begin
    case (byte_off)
      2'd0:    byte_sel = word_lo[7:0];
      2'd1:    byte_sel = word_lo[15:8];
      2'd2:    byte_sel = word_lo[23:16];
      default: byte_sel = word_lo[31:24];
    endcase
  end

  // Extend the selected lane to the datapath width
  always_comb begin
    case (load_type)
      LT_LB:   data = XLEN'($signed(byte_sel));
      LT_LH:   data = XLEN'($signed(half_sel));
      LT_LBU:  data = XLEN'(byte_sel);
      LT_LHU:  data = XLEN'(half_sel);
      default: data = XLEN'($signed(word_lo));
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: selects the result, waits for load data, commits to the RF.
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input logic               clk,
  input logic               rst_n,
  write_back_stage_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_MEM = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic            rd_we_q, rd_we_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  load_type_t      load_type_q, load_type_d;
  logic [1:0]      byte_off_q, byte_off_d;

  logic            accept;
  load_type_t      align_type;
  logic [1:0]      align_off;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] op_value;

  assign bus.in_ready = (state_q != ST_WAIT_MEM);
  assign accept       = bus.in_valid && bus.in_ready;

  // While waiting, align with the latched load kind; otherwise with the new one.
  assign align_type = (state_q == ST_WAIT_MEM) ? load_type_q : bus.load_type;
  assign align_off  = (state_q == ST_WAIT_MEM) ? byte_off_q  : bus.byte_off;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .word      (bus.mem_rdata),
    .load_type (align_type),
    .byte_off  (align_off),
    .data      (load_data)
  );

  // Non-memory operand; anything not PC/CSR falls back to the ALU result
  always_comb begin
    case (bus.wb_sel)
      WB_SEL_PC:  op_value = bus.pc_in + XLEN'(PC_STEP);
      WB_SEL_CSR: op_value = bus.csr_in;
      default:    op_value = bus.alu_in;
    endcase
  end

  // Next-state and latch logic
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_we_d     = rd_we_q;
    wdata_d     = wdata_q;
    load_type_d = load_type_q;
    byte_off_d  = byte_off_q;
    case (state_q)
      ST_WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          state_d = ST_COMMIT;
          wdata_d = load_data;
        end
      end
      default: begin
        // IDLE and COMMIT both accept; mem_rvalid matters only with a MEM accept.
        state_d = ST_IDLE;
        if (accept) begin
          rd_addr_d   = bus.rd_addr;
          rd_we_d     = bus.rd_we;
          load_type_d = bus.load_type;
          byte_off_d  = bus.byte_off;
          if (bus.wb_sel == WB_SEL_MEM) begin
            if (bus.mem_rvalid) begin
              state_d = ST_COMMIT;
              wdata_d = load_data;
            end else begin
              state_d = ST_WAIT_MEM;
            end
          end else begin
            state_d = ST_COMMIT;
            wdata_d = op_value;
          end
        end
      end
    endcase
  end

  // State registers; reset drops any pending load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      rd_we_q     <= 1'b0;
      wdata_q     <= '0;
      load_type_q <= LT_LW;
      byte_off_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_we_q     <= rd_we_d;
      wdata_q     <= wdata_d;
      load_type_q <= load_type_d;
      byte_off_q  <= byte_off_d;
    end
  end

  assign bus.rf_we     = (state_q == ST_COMMIT) && rd_we_q && (rd_addr_q != 5'd0);
  assign bus.rf_waddr  = rd_addr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.fwd_valid = bus.rf_we;
  assign bus.fwd_addr  = rd_addr_q;
  assign bus.fwd_data  = wdata_q;
  assign bus.busy      = (state_q == ST_WAIT_MEM);

endmodule
